// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronized rx, mid-bit sampling, 8N1 frames (8E1 when the
// UART_RX_PARITY_EN macro is defined), with one-cycle valid / frame_err / parity_err pulses.
module uart_rx #(
    parameter int unsigned CLK_FREQ = 12000000,
    parameter int unsigned BAUD     = 9600
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
    output logic       busy,
    output logic       parity_err
);

    localparam int unsigned DIV = CLK_FREQ / BAUD;
    localparam logic [10:0] CNT_LAST = 11'(DIV - 1);
    localparam logic [10:0] CNT_HALF = 11'(DIV / 2 - 1);

    if (DIV < 2 || DIV - 1 > 2047) begin : g_div_check
        $error("uart_rx: CLK_FREQ/BAUD - 1 must fit the 11-bit baud counter");
    end

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StStart    = 3'd1,
        StData     = 3'd2,
`ifdef UART_RX_PARITY_EN
        StParity   = 3'd3,
`endif
        StStop     = 3'd4,
        StWaitHigh = 3'd5
    } state_e;

    state_e      r_state;
    state_e      w_state_next;
    logic        r_sync1;
    logic        r_sync2;
    logic [10:0] r_cnt;
    logic [2:0]  r_idx;
    logic [7:0]  r_shift;
    logic [7:0]  r_data;
    logic        r_valid;
    logic        r_frame_err;

    logic        w_rxs;
    logic        w_cnt_last;
    logic        w_cnt_half;
    logic        w_cnt_clr;
    logic        w_sample_bit;
    logic        w_load;
    logic        w_ferr;
    logic        w_busy;
    logic        w_par_bad;

    assign w_rxs      = r_sync2;
    assign w_cnt_last = (r_cnt == CNT_LAST);
    assign w_cnt_half = (r_cnt == CNT_HALF);

    // State register
    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (!w_rxs) w_state_next = StStart;
            end
            StStart: begin
                if (w_cnt_half) w_state_next = w_rxs ? StIdle : StData;
            end
            StData: begin
                if (w_cnt_last && r_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                    w_state_next = StParity;
`else
                    w_state_next = StStop;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            StParity: begin
                if (w_cnt_last) w_state_next = StStop;
            end
`endif
            StStop: begin
                if (w_cnt_last) w_state_next = w_rxs ? StIdle : StWaitHigh;
            end
            StWaitHigh: begin
                if (w_rxs) w_state_next = StIdle;
            end
            default: w_state_next = StIdle;
        endcase
    end

    // Output / datapath control decode
    always_comb begin
        w_busy       = (r_state != StIdle);
        w_sample_bit = (r_state == StData) && w_cnt_last;
        w_cnt_clr    = (w_state_next != r_state) || w_cnt_last ||
                       (r_state == StIdle) || (r_state == StWaitHigh);
        w_load       = (r_state == StStop) && w_cnt_last && w_rxs && !w_par_bad;
        w_ferr       = (r_state == StStop) && w_cnt_last && !w_rxs;
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_sync1     <= 1'b1;
            r_sync2     <= 1'b1;
            r_cnt       <= 11'd0;
            r_idx       <= 3'd0;
            r_shift     <= 8'h00;
            r_data      <= 8'h00;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_sync1     <= rx;
            r_sync2     <= r_sync1;
            r_valid     <= w_load;
            r_frame_err <= w_ferr;
            if (w_cnt_clr) begin
                r_cnt <= 11'd0;
            end else begin
                r_cnt <= r_cnt + 11'd1;
            end
            if (r_state == StStart) begin
                r_idx <= 3'd0;
            end else if (w_sample_bit) begin
                r_idx <= r_idx + 3'd1;
            end
            if (w_sample_bit) begin
                r_shift[r_idx] <= w_rxs;
            end
            if (w_load) begin
                r_data <= r_shift;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    logic r_par_bad;
    logic r_parity_err;

    assign w_par_bad = r_par_bad;

    // Even parity: the parity bit makes the total count of ones even.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_par_bad    <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            r_parity_err <= (r_state == StStop) && w_cnt_last && w_rxs && r_par_bad;
            if (r_state == StParity && w_cnt_last) begin
                r_par_bad <= (w_rxs != ^r_shift);
            end
        end
    end

    assign parity_err = r_parity_err;
`else
    assign w_par_bad  = 1'b0;
    assign parity_err = 1'b0;
`endif

    assign data      = r_data;
    assign valid     = r_valid;
    assign frame_err = r_frame_err;
    assign busy      = w_busy;

endmodule
